icache_direct: RTL and testbench
================================

# icache_direct

Per-core instruction cache between the datapath fetch stage and the memory controller's instruction port. Direct-mapped, 16 sets, two-word (8-byte) blocks, read-only. Hits return in the same cycle. A miss runs a two-beat block fill through the controller's iREN/iaddr/iwait/iload handshake. One instance per CPU; each drives its own index of the controller's instruction arrays.

## Interface
Parameters:
- SETS, 16, number of direct-mapped sets; power of two; index width IDXW = log2(SETS)
- BLKWORDS, 2, words per block; fixed at 2 in this revision

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- nRST  in  1  reset, asynchronous, active-low
- imemREN  in  1  datapath fetch request
- imemaddr  in  32  fetch byte address; bits [1:0] ignored
- ihit  out  1  requested word valid on imemload this cycle
- imemload  out  32  instruction word
- iREN  out  1  instruction read request to the memory controller
- iaddr  out  32  word-aligned RAM address of the current fill beat
- iwait  in  1  controller busy; a beat completes in a cycle where iREN=1 and iwait=0
- iload  in  32  fill data; valid in the cycle iwait=0

## Operation
- Address split: tag = addr[31:3+IDXW] (25 bits at SETS=16); index = addr[2+IDXW:3]; word offset = addr[2]; byte bits [1:0] ignored.
- Each frame holds: valid, tag, data[2].
- Hit: imemREN=1, in IDLE, frame[index].valid=1, and tag match. On a hit, ihit=1 and imemload=data[offset], combinationally. Otherwise ihit=0 and imemload=0.
- Miss: imemREN=1, in IDLE, and not a hit.
  - Latch miss_tag and miss_index.
  - Go to FILL0.
- FILL0:
  - iREN=1; iaddr={miss_tag, miss_index, 1'b0, 2'b00}.
  - On iwait=0: store iload into a holding register; go to FILL1.
- FILL1:
  - iREN=1; iaddr={miss_tag, miss_index, 1'b1, 2'b00}.
  - On iwait=0, in a single edge: write data[0]=holding register and data[1]=iload; set tag=miss_tag and valid=1; go to IDLE.
- States: IDLE, FILL0, FILL1. No other states.
- ihit is forced to 0 in FILL0 and FILL1, even when the index matches a different valid frame.
- Evictions are silent (read-only cache, no write-back).

## Timing
- Reset values:
  - state=IDLE; all valid=0; holding register=0; miss_tag=0; miss_index=0.
  - iREN=0, iaddr=0, ihit=0, imemload=0.
  - Tag and data arrays are not reset.
- Hit latency: 0 cycles (same cycle as the request).
- Miss latency: the controller's beat latency ×2, plus 1 cycle to re-present as a hit in IDLE. Minimum is 3 cycles from the miss cycle to ihit=1, assuming the controller grants immediately.
- iREN stays high across the whole fill. The FILL0→FILL1 transition must not drop iREN for a cycle; the controller treats continuous iREN as back-to-back requests.
- iaddr changes only on a state edge. It is held stable while iwait=1.
- imemREN deasserted mid-fill: the fill completes and the block is installed; no abort.
- imemaddr changes mid-fill: ignored; the fill uses the latched miss address. The new address is evaluated in IDLE after the fill.
- A fill to an index whose frame is valid with a different tag overwrites that frame at the FILL1 completion edge only. The old contents stay readable only up to the miss cycle, because ihit is suppressed during the fill.
- Reset asserted mid-fill: return to IDLE immediately with all frames invalid and iREN=0. The controller must tolerate a dropped iREN.
- iwait=0 while iREN=0: ignored.

## Structure
- word_t (32 bits) comes from cpu_types_pkg.
- Add to cpu_types_pkg:
  - icache_state_t, enum {IDLE, FILL0, FILL1};
  - icache_frame_t, packed struct {valid, tag, data[2]};
  - constants ITAG_W, IIDX_W, IBLK_OFF.
- The address split is a packed struct icachef_t {tag, idx, blkoff, bytoff} in cpu_types_pkg.
- No sub-module. Frame storage is a flopped array of icache_frame_t inside this block. Control is a single next-state always_comb plus a single always_ff.

## Test plan
- Reset, then fetch 0x0000_0040 with the controller returning 0xAAAA_0001 and 0xAAAA_0002 (2 wait cycles each):
  - iaddr = 0x40, then 0x44;
  - then ihit=1 with imemload=0xAAAA_0001.
  - A following fetch of 0x44 hits in the same cycle with 0xAAAA_0002.
- Conflict: fill 0x0000_0040, then fetch 0x0000_00C0 (same index 8, different tag):
  - miss; fill from 0xC0/0xC4.
  - A re-fetch of 0x40 misses again.
- Mid-fill change: in FILL0, drop imemREN and switch imemaddr to 0x100.
  - The fill of 0x40/0x44 completes, with iREN continuous.
  - In IDLE, 0x100 then misses.
- Reset mid-fill: assert nRST low during FILL1.
  - Next cycle: iREN=0, ihit=0, state IDLE.
  - A fetch of the same address misses.
- Zero-wait controller (iwait=0 whenever iREN=1):
  - miss at cycle 0, beats at cycles 1–2, ihit at cycle 3.
  - Exactly 2 cycles with iREN=1.
- Sweep all 16 indices with distinct tags:
  - 16 fills.
  - A second pass gives 16 consecutive same-cycle hits with correct data and iREN=0 throughout.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word plus the instruction-cache frame, state and address layouts.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int IIDX_W   = 4;
  localparam int IBLK_OFF = 1;
  localparam int ITAG_W   = 32 - IIDX_W - IBLK_OFF - 2;

  typedef enum logic [1:0] {
    IDLE,
    FILL0,
    FILL1
  } icache_state_t;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t [1:0]       data;
  } icache_frame_t;

  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic              blkoff;
    logic [1:0]        bytoff;
  } icachef_t;

endpackage

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with same-cycle hits and a two-beat block fill.
module icache_direct
  import cpu_types_pkg::*;
#(
  parameter int SETS     = 16,
  parameter int BLKWORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  icache_state_t     r_state;
  icache_frame_t     r_frames [SETS];
  logic [ITAG_W-1:0] r_missTag;
  logic [IIDX_W-1:0] r_missIdx;
  word_t             r_hold;
  logic              r_iren;
  word_t             r_iaddr;

  icachef_t          w_addr;
  icache_frame_t     w_frame;
  logic              w_hit;
  icache_state_t     w_nextState;
  logic              w_unused;

  // Hits are only recognised in IDLE, so a fill in progress never returns stale data.
  always_comb begin
    w_addr      = icachef_t'(imemaddr);
    w_frame     = r_frames[w_addr.idx];
    w_hit       = (r_state == IDLE) && imemREN && w_frame.valid && (w_frame.tag == w_addr.tag);
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (imemREN && !w_hit) w_nextState = FILL0;
      FILL0:   if (!iwait) w_nextState = FILL1;
      FILL1:   if (!iwait) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  assign w_unused = &{1'b0, w_addr.bytoff};
  assign ihit     = w_hit;
  assign imemload = w_hit ? w_frame.data[w_addr.blkoff] : '0;
  assign iREN     = r_iren;
  assign iaddr    = r_iaddr;

  // Only valid bits are cleared on reset; tag and data are don't-care until a fill completes.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_missTag <= '0;
      r_missIdx <= '0;
      r_hold    <= '0;
      r_iren    <= 1'b0;
      r_iaddr   <= '0;
      for (int i = 0; i < SETS; i++) r_frames[i].valid <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (w_nextState == FILL0) begin
            r_missTag <= w_addr.tag;
            r_missIdx <= w_addr.idx;
            r_iren    <= 1'b1;
            r_iaddr   <= {w_addr.tag, w_addr.idx, 1'b0, 2'b00};
          end
        end
        FILL0: begin
          if (!iwait) begin
            r_hold  <= iload;
            r_iaddr <= {r_missTag, r_missIdx, 1'(BLKWORDS - 1), 2'b00};
          end
        end
        FILL1: begin
          if (!iwait) begin
            r_frames[r_missIdx] <= {1'b1, r_missTag, iload, r_hold};
            r_iren              <= 1'b0;
            r_iaddr             <= '0;
          end
        end
        default: begin
          r_iren  <= 1'b0;
          r_iaddr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct with a behavioural memory-controller model.
module tb_icache_direct;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  int    numCompared   = 0;
  int    numMismatched = 0;
  int    waitCycles    = 2;
  int    waitCnt       = 0;
  int    renCycles     = 0;
  word_t expQ [$];
  word_t beatQ [$];

  icache_direct #(.SETS(16), .BLKWORDS(2)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  always #5 CLK = ~CLK;

  function automatic word_t memData(input word_t a);
    return 32'hAAAA_0000 + (a >> 2) - 32'h0000_000F;
  endfunction

  function automatic word_t sweepAddr(input int i);
    return word_t'(((i + 32) << 7) | (i << 3));
  endfunction

  task automatic checkOutput(input string tag, input word_t obs, input word_t exp);
    numCompared++;
    if (obs !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Controller model: answers each beat after waitCycles busy cycles and checks beat addresses.
  always @(negedge CLK or negedge nRST) begin
    if (!nRST) begin
      waitCnt = 0;
      iwait   = 1'b0;
      iload   = 32'hDEAD_BEEF;
    end else if (iREN) begin
      renCycles++;
      checkOutput("fillNoHit", word_t'(ihit), 32'd0);
      if (waitCnt < waitCycles) begin
        iwait = 1'b1;
        waitCnt++;
      end else begin
        iwait   = 1'b0;
        iload   = memData(iaddr);
        waitCnt = 0;
        if (beatQ.size() == 0) checkOutput("beatUnexpected", iaddr, 32'hFFFF_FFFF);
        else                   checkOutput("beatAddr", iaddr, beatQ.pop_front());
      end
    end else begin
      iwait = 1'b0;
      iload = 32'hDEAD_BEEF;
    end
  end

  task automatic doReset();
    @(negedge CLK);
    nRST    = 1'b0;
    imemREN = 1'b0;
    beatQ.delete();
    expQ.delete();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic applyStimulus(input word_t addr, input bit expectMiss, input word_t midAddr);
    int    cycles;
    bit    hit;
    word_t expData;
    @(posedge CLK); #1;
    imemREN  = 1'b1;
    imemaddr = addr;
    if (expectMiss) begin
      beatQ.push_back({addr[31:3], 3'b000});
      beatQ.push_back({addr[31:3], 3'b100});
    end
    expQ.push_back(memData({midAddr[31:2], 2'b00}));
    cycles = 0;
    hit    = 1'b0;
    while (!hit && cycles <= 40) begin
      @(negedge CLK);
      if (ihit) hit = 1'b1;
      else begin
        cycles++;
        if (cycles == 1 && midAddr != addr) begin
          @(posedge CLK); #1;
          imemaddr = midAddr;
        end
      end
    end
    checkOutput("hitSeen", word_t'(hit), 32'd1);
    checkOutput("latency", word_t'(cycles), expectMiss ? word_t'(2 * (waitCycles + 1) + 1) : 32'd0);
    expData = (expQ.size() != 0) ? expQ.pop_front() : 32'hFFFF_FFFF;
    if (hit) checkOutput("hitData", imemload, expData);
    @(posedge CLK); #1;
    imemREN = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  guard;
    nRST     = 1'b0;
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0040;
    #12;
    checkOutput("rstIREN", word_t'(iREN), 32'd0);
    checkOutput("rstIaddr", iaddr, 32'd0);
    checkOutput("rstIhit", word_t'(ihit), 32'd0);
    checkOutput("rstImemload", imemload, 32'd0);
    imemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;

    // Basic fill and same-block hit, then a conflicting tag on index 8.
    applyStimulus(32'h0000_0040, 1'b1, 32'h0000_0040);
    applyStimulus(32'h0000_0044, 1'b0, 32'h0000_0044);
    applyStimulus(32'h0000_00C0, 1'b1, 32'h0000_00C0);
    applyStimulus(32'h0000_00C4, 1'b0, 32'h0000_00C4);
    applyStimulus(32'h0000_0040, 1'b1, 32'h0000_0040);

    // Fetch request dropped and address changed during FILL0.
    doReset();
    renCycles = 0;
    @(posedge CLK); #1;
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0040;
    beatQ.push_back(32'h0000_0040);
    beatQ.push_back(32'h0000_0044);
    @(posedge CLK); #1;
    imemREN  = 1'b0;
    imemaddr = 32'h0000_0100;
    guard = 0;
    do begin
      @(negedge CLK); #1;
      guard++;
    end while ((iREN || beatQ.size() != 0) && guard < 40);
    checkOutput("midFillDone", word_t'(guard < 40), 32'd1);
    checkOutput("midFillRenCycles", word_t'(renCycles), 32'd6);
    applyStimulus(32'h0000_0100, 1'b1, 32'h0000_0100);
    applyStimulus(32'h0000_0044, 1'b0, 32'h0000_0044);

    // Hit suppression while filling: address swaps to a cached block mid-fill.
    applyStimulus(32'h0000_0300, 1'b1, 32'h0000_0040);

    // Reset asserted during FILL1.
    @(posedge CLK); #1;
    imemREN  = 1'b1;
    imemaddr = 32'h0000_00C0;
    beatQ.push_back(32'h0000_00C0);
    beatQ.push_back(32'h0000_00C4);
    guard = 0;
    do begin
      @(negedge CLK); #1;
      guard++;
    end while (beatQ.size() != 1 && guard < 40);
    checkOutput("reachFill1", word_t'(guard < 40), 32'd1);
    @(posedge CLK); #2;
    nRST = 1'b0;
    beatQ.delete();
    #1;
    checkOutput("midRstIREN", word_t'(iREN), 32'd0);
    checkOutput("midRstIhit", word_t'(ihit), 32'd0);
    checkOutput("midRstIaddr", iaddr, 32'd0);
    imemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    applyStimulus(32'h0000_00C0, 1'b1, 32'h0000_00C0);
    applyStimulus(32'h0000_0040, 1'b1, 32'h0000_0040);

    // Zero-wait controller: exactly two request cycles per fill.
    doReset();
    waitCycles = 0;
    renCycles  = 0;
    applyStimulus(32'h0000_0200, 1'b1, 32'h0000_0200);
    checkOutput("zeroWaitRenCycles", word_t'(renCycles), 32'd2);

    // Sweep every index with a distinct tag, then read back with back-to-back hits.
    waitCycles = 1;
    doReset();
    for (int i = 0; i < 16; i++) applyStimulus(sweepAddr(i), 1'b1, sweepAddr(i));
    renCycles = 0;
    @(posedge CLK); #1;
    for (int i = 0; i < 16; i++) begin
      word_t a;
      a        = sweepAddr(i) | ((i % 2 == 1) ? 32'd4 : 32'd0);
      imemREN  = 1'b1;
      imemaddr = a;
      expQ.push_back(memData(a));
      @(negedge CLK);
      checkOutput("sweepHit", word_t'(ihit), 32'd1);
      checkOutput("sweepData", imemload, expQ.pop_front());
      @(posedge CLK); #1;
    end
    imemREN = 1'b0;
    checkOutput("sweepRenCycles", word_t'(renCycles), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
